// File: rtl/led_pkg.sv
// Shared definitions for the 74HC595 LED driver: FSM states and the
// derivation of the phase length and counter widths.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  // sclk cycles per srclk half-period; never below one cycle.
  function automatic int calc_div(input int sclk_freq, input int shift_freq);
    int d;
    d = sclk_freq / (2 * shift_freq);
    return (d < 1) ? 1 : d;
  endfunction

  // Bits needed to hold values 0..n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hc595_driver.sv
// Serialises one WIDTH-bit frame into a 74HC595 (DS/SHCP/STCP) per accepted request.
// Optional macro HC595_CHANGE_ONLY_EN: frames equal to the last one sent are consumed without shifting.
module hc595_driver
  import led_pkg::*;
#(
  parameter int SCLK_FREQ  = 50_000_000,
  parameter int SHIFT_FREQ = 12_500_000,
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             ready,
  output logic             ser,
  output logic             srclk,
  output logic             rclk
);

  localparam int DIV = calc_div(SCLK_FREQ, SHIFT_FREQ);
  localparam int PW  = cnt_width(DIV);
  localparam int BW  = cnt_width(WIDTH);
  localparam logic [PW-1:0] PH_LAST  = PW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  state_t           state;
  logic [PW-1:0]    ph_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shreg;
  logic             fresh;

  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

`ifdef HC595_CHANGE_ONLY_EN
  logic [WIDTH-1:0] last_sent;
  assign fresh = (data_in != last_sent);
`else
  assign fresh = 1'b1;
`endif

  wire ph_done = (ph_cnt == PH_LAST);

  // All outputs are registered so the pins change exactly on phase boundaries.
  always_ff @(posedge sclk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch;
    // every state register, including the shift register, is cleared.
    if (rst) begin
      state   <= IDLE;
      ready   <= 1'b1;
      ser     <= 1'b0;
      srclk   <= 1'b0;
      rclk    <= 1'b0;
      ph_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
`ifdef HC595_CHANGE_ONLY_EN
      last_sent <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments let every branch read pre-edge values.
      case (state)
        IDLE: begin
          if (data_valid && fresh) begin
            shreg  <= data_in;
            ser    <= first_bit(data_in);
            ready  <= 1'b0;
            ph_cnt <= '0;
            state  <= SHIFT_LO;
`ifdef HC595_CHANGE_ONLY_EN
            last_sent <= data_in;
`endif
          end
        end

        SHIFT_LO: begin
          if (ph_done) begin
            ph_cnt <= '0;
            srclk  <= 1'b1;
            state  <= SHIFT_HI;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end

        SHIFT_HI: begin
          if (ph_done) begin
            ph_cnt <= '0;
            srclk  <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              rclk    <= 1'b1;
              state   <= LATCH;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= advance(shreg);
              ser     <= first_bit(advance(shreg));
              state   <= SHIFT_LO;
            end
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end

        LATCH: begin
          if (ph_done) begin
            ph_cnt <= '0;
            rclk   <= 1'b0;
            ready  <= 1'b1;
            state  <= IDLE;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hc595_driver.sv
// Self-checking bench for hc595_driver (WIDTH=8, DIV=2): scoreboarded serial stream plus cycle-exact timing checks.
module tb_hc595_driver;

`ifdef HC595_CHANGE_ONLY_EN
  localparam bit CO = 1'b1;
`else
  localparam bit CO = 1'b0;
`endif

  logic       sclk = 1'b0;
  logic       rst  = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       ready, ser, srclk, rclk;
  logic [7:0] data_in_l = 8'h00;
  logic       data_valid_l = 1'b0;
  logic       ready_l, ser_l, srclk_l, rclk_l;

  hc595_driver #(.SCLK_FREQ(50_000_000), .SHIFT_FREQ(12_500_000), .WIDTH(8), .MSB_FIRST(1)) u_msb (
    .sclk(sclk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .ready(ready), .ser(ser), .srclk(srclk), .rclk(rclk)
  );

  hc595_driver #(.SCLK_FREQ(50_000_000), .SHIFT_FREQ(12_500_000), .WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .sclk(sclk), .rst(rst), .data_in(data_in_l), .data_valid(data_valid_l),
    .ready(ready_l), .ser(ser_l), .srclk(srclk_l), .rclk(rclk_l)
  );

  always #5 sclk = ~sclk;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         rclk_cnt = 0;
  bit         mon_en = 1'b0;
  logic       prev_srclk = 1'b0;
  logic       prev_rclk = 1'b0;
  logic [7:0] emu = 8'h00;
  logic       bit_q[$];
  logic [7:0] frame_q[$];

  // Advance one cycle; outputs are sampled on the falling edge where the
  // scoreboard emulates the external 74HC595.
  task automatic step();
    logic       exp_b;
    logic [7:0] exp_f;
    @(posedge sclk);
    cyc++;
    @(negedge sclk);
    if (mon_en) begin
      if (srclk === 1'b1 && prev_srclk !== 1'b1) begin
        emu = {emu[6:0], ser};
        total++;
        if (bit_q.size() == 0) begin
          bad++;
          $display("FAIL sb_bit: unexpected srclk rise, ser=%b", ser);
        end else begin
          exp_b = bit_q.pop_front();
          if (ser !== exp_b) begin
            bad++;
            $display("FAIL sb_bit: ser=%b expected %b at cycle %0d", ser, exp_b, cyc);
          end
        end
      end
      if (rclk === 1'b1 && prev_rclk !== 1'b1) begin
        rclk_cnt++;
        total++;
        if (frame_q.size() == 0) begin
          bad++;
          $display("FAIL sb_frame: unexpected rclk pulse, latched=%h", emu);
        end else begin
          exp_f = frame_q.pop_front();
          if (emu !== exp_f) begin
            bad++;
            $display("FAIL sb_frame: latched=%h expected %h", emu, exp_f);
          end
        end
      end
      total++;
      if (srclk === 1'b1 && rclk === 1'b1) begin
        bad++;
        $display("FAIL overlap: srclk and rclk both high at cycle %0d", cyc);
      end
    end
    prev_srclk = srclk;
    prev_rclk  = rclk;
  endtask

  task automatic push_frame(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) bit_q.push_back(v[i]);
    frame_q.push_back(v);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL wait_ready: ready=%b expected 1 within 100 cycles", ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data_valid = 1'b0;
    repeat (3) step();
    total++;
    if ({ready, ser, srclk, rclk} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_msb: ready/ser/srclk/rclk=%b expected 1000", {ready, ser, srclk, rclk});
    end
    total++;
    if ({ready_l, ser_l, srclk_l, rclk_l} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_lsb: ready/ser/srclk/rclk=%b expected 1000", {ready_l, ser_l, srclk_l, rclk_l});
    end
    rst = 1'b0;
    mon_en = 1'b1;
    step();
    total++;
    if ({ready, ser, srclk, rclk} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_release: ready/ser/srclk/rclk=%b expected 1000", {ready, ser, srclk, rclk});
    end
  endtask

  // A5 with valid held; data switches to FF mid-frame and is picked up back-to-back.
  task automatic test_frame_back_to_back();
    logic [7:0] pat = 8'hA5;
    logic       exp_s, exp_r, exp_rdy, exp_d;
    wait_ready();
    data_in = 8'hA5;
    data_valid = 1'b1;
    push_frame(8'hA5);
    for (int k = 1; k <= 36; k++) begin
      step();
      exp_s   = (k <= 32) && (((k - 1) % 4) >= 2);
      exp_r   = (k == 33) || (k == 34);
      exp_rdy = (k == 35);
      total++;
      if (srclk !== exp_s) begin
        bad++;
        $display("FAIL frame_srclk: T0+%0d srclk=%b expected %b", k, srclk, exp_s);
      end
      total++;
      if (rclk !== exp_r) begin
        bad++;
        $display("FAIL frame_rclk: T0+%0d rclk=%b expected %b", k, rclk, exp_r);
      end
      total++;
      if (ready !== exp_rdy) begin
        bad++;
        $display("FAIL frame_ready: T0+%0d ready=%b expected %b", k, ready, exp_rdy);
      end
      if (k <= 32) begin
        exp_d = pat[7 - ((k - 1) / 4)];
        total++;
        if (ser !== exp_d) begin
          bad++;
          $display("FAIL frame_ser: T0+%0d ser=%b expected %b", k, ser, exp_d);
        end
      end
      if (k == 36) begin
        total++;
        if (ser !== 1'b1) begin
          bad++;
          $display("FAIL b2b_first_bit: ser=%b expected 1", ser);
        end
        data_valid = 1'b0;
      end
      if (k == 10) begin
        data_in = 8'hFF;
        push_frame(8'hFF);
      end
    end
    wait_ready();
  endtask

  task automatic test_abort();
    int rc;
    wait_ready();
    data_in = 8'hC3;
    data_valid = 1'b1;
    for (int i = 7; i >= 0; i--) bit_q.push_back(data_in[i]);
    for (int k = 1; k <= 12; k++) begin
      step();
      data_valid = 1'b0;
    end
    rst = 1'b1;
    rc = rclk_cnt;
    step();
    total++;
    if ({ready, ser, srclk, rclk} !== 4'b1000) begin
      bad++;
      $display("FAIL abort_outputs: ready/ser/srclk/rclk=%b expected 1000", {ready, ser, srclk, rclk});
    end
    rst = 1'b0;
    bit_q.delete();
    repeat (40) step();
    total++;
    if (rclk_cnt !== rc) begin
      bad++;
      $display("FAIL abort_no_latch: rclk pulses=%0d expected %0d", rclk_cnt, rc);
    end
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_idle: ready=%b expected 1", ready);
    end
  endtask

  // Offer one frame for a single cycle; accept says whether a shift must follow.
  task automatic offer(input logic [7:0] v, input bit accept);
    wait_ready();
    data_in = v;
    data_valid = 1'b1;
    if (accept) push_frame(v);
    step();
    data_valid = 1'b0;
    total++;
    if (ready !== !accept) begin
      bad++;
      $display("FAIL offer_ready: data=%h ready=%b expected %b", v, ready, !accept);
    end
    repeat (40) step();
  endtask

  task automatic test_change_only();
    int rc0, exp_n;
    rc0 = rclk_cnt;
    offer(8'h00, !CO);
    offer(8'h3C, 1'b1);
    offer(8'h3C, !CO);
    exp_n = CO ? 1 : 3;
    total++;
    if (rclk_cnt - rc0 !== exp_n) begin
      bad++;
      $display("FAIL change_only_frames: frames=%0d expected %0d", rclk_cnt - rc0, exp_n);
    end
  endtask

  task automatic test_lsb_first();
    logic exp_d;
    data_in_l = 8'h01;
    data_valid_l = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      step();
      data_valid_l = 1'b0;
      if (k <= 32) begin
        exp_d = (k <= 4);
        total++;
        if (ser_l !== exp_d) begin
          bad++;
          $display("FAIL lsb_ser: T0+%0d ser=%b expected %b", k, ser_l, exp_d);
        end
      end
      if (k == 33 || k == 35) begin
        total++;
        if (rclk_l !== (k == 33)) begin
          bad++;
          $display("FAIL lsb_rclk: T0+%0d rclk=%b expected %b", k, rclk_l, (k == 33));
        end
      end
    end
    total++;
    if (ready_l !== 1'b1) begin
      bad++;
      $display("FAIL lsb_ready: ready=%b expected 1", ready_l);
    end
  endtask

  initial begin
    test_reset();
    test_frame_back_to_back();
    test_abort();
    test_change_only();
    test_lsb_first();
    total++;
    if (bit_q.size() != 0 || frame_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: bits left=%0d frames left=%0d expected 0", bit_q.size(), frame_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
